// File: rtl/conv_pkg.sv
// Shared definitions for the conv array skew stage: lane widths, FSM state
// encoding and the maximum lane-delay helper.
package conv_pkg;

  localparam int LANE_DIN_W  = 8;
  localparam int LANE_DOUT_W = 9;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic int max_dly(input int ch_num, input int skew_step);
    return (ch_num - 1) * skew_step;
  endfunction

  // Drain counter has to hold max_dly; never narrower than one bit.
  function automatic int cnt_width(input int d);
    return (d < 1) ? 1 : $clog2(d + 1);
  endfunction

endpackage

// File: rtl/skew_lane_dly.sv
// One lane delay chain of DLY (data, valid) registers; DLY==0 is a wire.
// clr is a synchronous hold-in-reset used when this chain set is not selected.
module skew_lane_dly #(
  parameter int DLY = 1,
  parameter int W   = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  input  logic         vin,
  output logic [W-1:0] dout,
  output logic         vout
);

  if (DLY == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = ^{clk, rstn, clr, en};
    assign dout = din;
    assign vout = vin;
  end else begin : g_chain
    logic [W-1:0] d_q [DLY];
    logic         v_q [DLY];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int i = 0; i < DLY; i++) begin
          d_q[i] <= '0;
          v_q[i] <= 1'b0;
        end
      end else if (clr) begin
        for (int i = 0; i < DLY; i++) begin
          d_q[i] <= '0;
          v_q[i] <= 1'b0;
        end
      end else if (en) begin
        // A non-accepted cycle enters as a bubble with zero data.
        d_q[0] <= vin ? din : '0;
        v_q[0] <= vin;
        for (int i = 1; i < DLY; i++) begin
          d_q[i] <= d_q[i-1];
          v_q[i] <= v_q[i-1];
        end
      end
    end

    assign dout = d_q[DLY-1];
    assign vout = v_q[DLY-1];
  end

endmodule

// File: rtl/conv_skew_aligner.sv
// Diagonal skew / de-skew stage for the systolic conv array with per-lane valid,
// stall, frame drain and done pulse. Optional macro SKEW_ZERO_GATE_EN zeroes invalid lanes.
module conv_skew_aligner
  import conv_pkg::*;
#(
  parameter int CH_NUM    = 9,
  parameter int DIN_W     = LANE_DIN_W,
  parameter int DOUT_W    = LANE_DOUT_W,
  parameter int SKEW_STEP = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en,
  input  logic                     skew_dir,
  input  logic                     sign_mode,
  input  logic                     in_vld,
  input  logic                     in_last,
  output logic                     in_rdy,
  input  logic [CH_NUM*DIN_W-1:0]  din,
  output logic [CH_NUM*DOUT_W-1:0] dout,
  output logic [CH_NUM-1:0]        dout_vld,
  output logic                     busy,
  output logic                     done
);

  localparam int D     = max_dly(CH_NUM, SKEW_STEP);
  localparam int CNT_W = cnt_width(D);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(D);

  if (DOUT_W < DIN_W) begin : g_bad_width
    $error("conv_skew_aligner: DOUT_W must be >= DIN_W");
  end
  if (CH_NUM < 1 || SKEW_STEP < 1) begin : g_bad_geom
    $error("conv_skew_aligner: CH_NUM and SKEW_STEP must be >= 1");
  end

  function automatic logic [DOUT_W-1:0] extend(input logic [DIN_W-1:0] x, input logic sgn);
    logic [DOUT_W-1:0] r;
    r = '0;
    r[DIN_W-1:0] = x;
    for (int i = DIN_W; i < DOUT_W; i++) r[i] = sgn & x[DIN_W-1];
    return r;
  endfunction

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             dir_q;
  logic             sign_q;
  logic             accept;
  logic             dir_eff;
  logic             sign_eff;

  assign in_rdy = en & (state != ST_DRAIN);
  assign accept = in_vld & in_rdy;
  assign busy   = (state != ST_IDLE);

  // In IDLE the live mode steers the first beat; afterwards the latched copy rules.
  assign dir_eff  = (state == ST_IDLE) ? skew_dir  : dir_q;
  assign sign_eff = (state == ST_IDLE) ? sign_mode : sign_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      dir_q  <= 1'b0;
      sign_q <= 1'b0;
    end else begin
      done <= 1'b0;
      if (en) begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              dir_q  <= skew_dir;
              sign_q <= sign_mode;
              if (in_last) begin
                state <= ST_DRAIN;
                cnt   <= CNT_LOAD;
              end else begin
                state <= ST_RUN;
              end
            end
          end
          ST_RUN: begin
            if (accept && in_last) begin
              state <= ST_DRAIN;
              cnt   <= CNT_LOAD;
            end
          end
          ST_DRAIN: begin
            if (cnt == '0) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Lane chains: both skew and de-skew sets exist, the unselected one held clear.
  for (genvar k = 0; k < CH_NUM; k++) begin : g_lane
    logic [DIN_W-1:0] sk_d;
    logic [DIN_W-1:0] ds_d;
    logic [DIN_W-1:0] sel_d;
    logic             sk_v;
    logic             ds_v;
    logic             sel_v;

    skew_lane_dly #(.DLY(k * SKEW_STEP), .W(DIN_W)) u_skew (
      .clk  (clk),
      .rstn (rstn),
      .clr  (dir_eff),
      .en   (en),
      .din  (din[k*DIN_W +: DIN_W]),
      .vin  (accept),
      .dout (sk_d),
      .vout (sk_v)
    );

    skew_lane_dly #(.DLY((CH_NUM - 1 - k) * SKEW_STEP), .W(DIN_W)) u_deskew (
      .clk  (clk),
      .rstn (rstn),
      .clr  (~dir_eff),
      .en   (en),
      .din  (din[k*DIN_W +: DIN_W]),
      .vin  (accept),
      .dout (ds_d),
      .vout (ds_v)
    );

    assign sel_d       = dir_eff ? ds_d : sk_d;
    assign sel_v       = dir_eff ? ds_v : sk_v;
    assign dout_vld[k] = sel_v;

`ifdef SKEW_ZERO_GATE_EN
    assign dout[k*DOUT_W +: DOUT_W] = sel_v ? extend(sel_d, sign_eff) : '0;
`else
    assign dout[k*DOUT_W +: DOUT_W] = extend(sel_d, sign_eff);
`endif
  end

endmodule

// File: tb/tb_conv_skew_aligner.sv
// Bench for conv_skew_aligner: directed frames plus randomized traffic against a
// timeline reference model; a second instance covers a wider parameter set.
module tb_conv_skew_aligner;

  localparam int CH  = 9;
  localparam int DW  = 8;
  localparam int OW  = 9;
  localparam int ST  = 1;
  localparam int DM  = (CH - 1) * ST;
  localparam int CH2 = 4;
  localparam int DW2 = 16;
  localparam int OW2 = 20;
  localparam int ST2 = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b0;
  logic skew_dir = 1'b0;
  logic sign_mode = 1'b0;
  logic in_vld = 1'b0;
  logic in_last = 1'b0;
  logic [CH*DW-1:0] din = '0;
  logic             in_rdy;
  logic [CH*OW-1:0] dout;
  logic [CH-1:0]    dout_vld;
  logic             busy;
  logic             done;

  logic en2 = 1'b1;
  logic skew_dir2 = 1'b0;
  logic sign_mode2 = 1'b1;
  logic in_vld2 = 1'b0;
  logic in_last2 = 1'b0;
  logic [CH2*DW2-1:0] din2 = '0;
  logic               in_rdy2;
  logic [CH2*OW2-1:0] dout2;
  logic [CH2-1:0]     dout_vld2;
  logic               busy2;
  logic               done2;

  always #5 clk = ~clk;

  conv_skew_aligner #(.CH_NUM(CH), .DIN_W(DW), .DOUT_W(OW), .SKEW_STEP(ST)) dut (
    .clk(clk), .rstn(rstn), .en(en), .skew_dir(skew_dir), .sign_mode(sign_mode),
    .in_vld(in_vld), .in_last(in_last), .in_rdy(in_rdy), .din(din), .dout(dout),
    .dout_vld(dout_vld), .busy(busy), .done(done)
  );

  conv_skew_aligner #(.CH_NUM(CH2), .DIN_W(DW2), .DOUT_W(OW2), .SKEW_STEP(ST2)) dut2 (
    .clk(clk), .rstn(rstn), .en(en2), .skew_dir(skew_dir2), .sign_mode(sign_mode2),
    .in_vld(in_vld2), .in_last(in_last2), .in_rdy(in_rdy2), .din(din2), .dout(dout2),
    .dout_vld(dout_vld2), .busy(busy2), .done(done2)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference timeline: one entry per enabled clock edge holding what was accepted.
  logic [CH*DW-1:0] hd [4096];
  bit               hv [4096];
  int n = 0;
  int base = 0;
  bit m_active = 0;
  bit m_drain = 0;
  bit m_done = 0;
  bit fdir = 0;
  bit fsign = 0;
  int left = 0;

  task automatic check_outputs();
    bit ed, es, acc, v;
    int d, idx;
    logic [DW-1:0] x;
    logic [OW-1:0] e;
    ed  = m_active ? fdir : skew_dir;
    es  = m_active ? fsign : sign_mode;
    acc = in_vld & en & ~m_drain;
    chk("in_rdy", 64'(in_rdy), 64'(en & ~m_drain));
    chk("busy", 64'(busy), 64'(m_active));
    chk("done", 64'(done), 64'(m_done));
    for (int k = 0; k < CH; k++) begin
      d = ed ? (CH - 1 - k) * ST : k * ST;
      if (d == 0) begin
        v = acc;
        x = din[k*DW +: DW];
      end else begin
        idx = n - d;
        if (idx < base) begin
          v = 1'b0;
          x = '0;
        end else begin
          v = hv[idx];
          x = hd[idx][k*DW +: DW];
        end
      end
      e = OW'(x);
      if (es && x[DW-1]) e[OW-1:DW] = '1;
`ifdef SKEW_ZERO_GATE_EN
      if (!v) e = '0;
`endif
      chk($sformatf("dout[%0d] t=%0t", k, $time), 64'(dout[k*OW +: OW]), 64'(e));
      chk($sformatf("dout_vld[%0d] t=%0t", k, $time), 64'(dout_vld[k]), 64'(v));
    end
  endtask

  task automatic model_edge();
    bit acc;
    if (!rstn) return;
    m_done = 1'b0;
    if (!en) return;
    acc = in_vld & ~m_drain;
    if (n < 4096) begin
      hv[n] = acc;
      hd[n] = acc ? din : '0;
      n++;
    end
    if (m_drain) begin
      left--;
      if (left == 0) begin
        m_drain  = 1'b0;
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end else if (acc) begin
      if (!m_active) begin
        m_active = 1'b1;
        fdir     = skew_dir;
        fsign    = sign_mode;
      end
      if (in_last) begin
        m_drain = 1'b1;
        left    = DM + 1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input int c);
    rstn     = 1'b0;
    base     = n;
    m_active = 1'b0;
    m_drain  = 1'b0;
    m_done   = 1'b0;
    fdir     = 1'b0;
    fsign    = 1'b0;
    repeat (c) cycle();
    rstn = 1'b1;
  endtask

  task automatic rand_din();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    din = r[CH*DW-1:0];
  endtask

  initial begin
    do_reset(3);
    en = 1'b1;

    // Single beat, skew, sign-extend 0x80 on every lane.
    skew_dir = 1'b0; sign_mode = 1'b1; din = {CH{8'h80}};
    in_vld = 1'b1; in_last = 1'b1;
    cycle();
    in_vld = 1'b0; in_last = 1'b0; din = '0;
    repeat (DM + 4) cycle();

    // Single beat, de-skew, zero-extend, lane k = k+1.
    skew_dir = 1'b1; sign_mode = 1'b0;
    for (int k = 0; k < CH; k++) din[k*DW +: DW] = DW'(k + 1);
    in_vld = 1'b1; in_last = 1'b1;
    cycle();
    in_vld = 1'b0; in_last = 1'b0; din = '0;
    repeat (DM + 4) cycle();

    // Three-beat frame with a 4-cycle stall mid-drain.
    skew_dir = 1'b0; sign_mode = 1'b1;
    for (int b = 0; b < 3; b++) begin
      rand_din(); in_vld = 1'b1; in_last = (b == 2);
      cycle();
    end
    in_vld = 1'b0; in_last = 1'b0;
    repeat (3) cycle();
    en = 1'b0; in_vld = 1'b1;
    repeat (4) cycle();
    en = 1'b1; in_vld = 1'b0;
    repeat (DM + 4) cycle();

    // Bubble pattern 1,0,1 with mode inputs toggled mid-frame; input offered during drain.
    skew_dir = 1'b0; sign_mode = 1'b0; rand_din(); in_vld = 1'b1; in_last = 1'b0;
    cycle();
    skew_dir = 1'b1; sign_mode = 1'b1; rand_din(); in_vld = 1'b0;
    cycle();
    rand_din(); in_vld = 1'b1; in_last = 1'b1;
    cycle();
    in_last = 1'b0;
    repeat (4) begin rand_din(); cycle(); end
    in_vld = 1'b0;
    repeat (DM + 2) cycle();

    // Reset while draining with cnt at 5, then a normal frame.
    skew_dir = 1'b0; sign_mode = 1'b1; din = {CH{8'hA5}};
    in_vld = 1'b1; in_last = 1'b1;
    cycle();
    in_vld = 1'b0; in_last = 1'b0;
    repeat (3) cycle();
    do_reset(2);
    skew_dir = 1'b1; sign_mode = 1'b1; rand_din(); in_vld = 1'b1; in_last = 1'b1;
    cycle();
    in_vld = 1'b0; in_last = 1'b0;
    repeat (DM + 4) cycle();

    // Randomized frames: gaps, stalls, mode noise mid-frame.
    for (int f = 0; f < 40; f++) begin
      int beats, got, guard;
      beats = $urandom_range(1, 5);
      got = 0;
      guard = 0;
      skew_dir = 1'($urandom);
      sign_mode = 1'($urandom);
      while (!m_drain && guard < 100) begin
        en = ($urandom_range(0, 9) != 0);
        in_vld = ($urandom_range(0, 3) != 0);
        rand_din();
        in_last = (got == beats - 1);
        if (m_active) begin
          skew_dir = 1'($urandom);
          sign_mode = 1'($urandom);
        end
        if (in_vld & en & ~m_drain) got++;
        cycle();
        guard++;
      end
      in_last = 1'b0;
      guard = 0;
      while (m_active && guard < 200) begin
        en = ($urandom_range(0, 4) != 0);
        in_vld = 1'($urandom);
        rand_din();
        skew_dir = 1'($urandom);
        cycle();
        guard++;
      end
      en = 1'b1;
      in_vld = 1'b0;
      repeat ($urandom_range(0, 3)) cycle();
    end

    // Wide-lane instance: D=6, sign extension of 16'h8001 to 20 bits.
    din2 = {CH2{16'h8001}}; in_vld2 = 1'b1; in_last2 = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      for (int k = 0; k < CH2; k++) begin
        chk($sformatf("p2_dout[%0d] t=%0d", k, t), 64'(dout2[k*OW2 +: OW2]),
            (t == k * ST2) ? 64'h0F8001 : 64'h0);
        chk($sformatf("p2_vld[%0d] t=%0d", k, t), 64'(dout_vld2[k]), 64'(t == k * ST2));
      end
      chk($sformatf("p2_done t=%0d", t), 64'(done2), 64'(t == 8));
      chk($sformatf("p2_busy t=%0d", t), 64'(busy2), 64'(t >= 1 && t <= 7));
      chk($sformatf("p2_in_rdy t=%0d", t), 64'(in_rdy2), 64'(t == 0 || t >= 8));
      @(posedge clk);
      #1;
      in_vld2 = 1'b0; in_last2 = 1'b0; din2 = '0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
